// File: rtl/port_rd_backend.sv
// Per-egress-port read engine: takes one packet descriptor, streams its words out of
// the selected SRAM with sequential reads, and reports the freed space on completion.
module port_rd_backend #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned LEN_W      = 9,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_avail,
  input  logic [4:0]        pkt_sram,
  input  logic [ADDR_W-1:0] pkt_head,
  input  logic [LEN_W-1:0]  pkt_len,
  output logic              pkt_ack,
  output logic              sram_rd_en,
  output logic [4:0]        sram_rd_sel,
  output logic [ADDR_W-1:0] sram_rd_addr,
  input  logic [DATA_W-1:0] sram_rd_data,
  input  logic              ready,
  output logic              rd_sop,
  output logic              rd_vld,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_eop,
  output logic              done,
  output logic [4:0]        done_sram,
  output logic [LEN_W-1:0]  done_len,
  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [4:0]            sram_q, sram_d;
  logic [ADDR_W-1:0]     head_q, head_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  eop_q, eop_d;
  logic [4:0]            done_sram_q, done_sram_d;
  logic [LEN_W-1:0]      done_len_q, done_len_d;

  logic issue;
  logic last_issue;
  logic tail_only;

  assign issue      = (state_q == ISSUE);
  assign last_issue = issue && (cnt_q == (len_q - LEN_W'(1)));

  assign pkt_ack      = (state_q == IDLE) && pkt_avail && ready && !rst;
  assign busy         = (state_q != IDLE) && !rst;
  assign sram_rd_en   = issue;
  assign sram_rd_sel  = issue ? sram_q : '0;
  assign sram_rd_addr = issue ? (head_q + ADDR_W'(cnt_q)) : '0;
  assign rd_sop       = issue && (cnt_q == '0);
  assign rd_vld       = vld_q[RD_LATENCY-1];
  assign rd_data      = rd_vld ? sram_rd_data : data_q;
  assign rd_eop       = eop_q;
  assign done         = eop_q;
  assign done_sram    = done_sram_q;
  assign done_len     = done_len_q;

  // The last word is on the bus when only the tail of the valid pipeline is set,
  // since nothing is issued once DRAIN is entered.
  always_comb begin
    tail_only = vld_q[RD_LATENCY-1];
    for (int unsigned i = 0; i + 1 < RD_LATENCY; i++) begin
      if (vld_q[i]) tail_only = 1'b0;
    end
  end

  always_comb begin
    vld_d    = '0;
    vld_d[0] = issue;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    sram_d      = sram_q;
    head_d      = head_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    eop_d       = 1'b0;
    done_sram_d = done_sram_q;
    done_len_d  = done_len_q;
    data_d      = rd_data;
    case (state_q)
      IDLE: begin
        if (pkt_ack) begin
          sram_d = pkt_sram;
          head_d = pkt_head;
          len_d  = pkt_len;
          cnt_d  = '0;
          // Zero-length descriptors are consumed without generating any traffic.
          if (pkt_len != '0) state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + LEN_W'(1);
        if (last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        if (tail_only) begin
          eop_d       = 1'b1;
          done_sram_d = sram_q;
          done_len_d  = len_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sram_q      <= '0;
      head_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      vld_q       <= '0;
      data_q      <= '0;
      eop_q       <= 1'b0;
      done_sram_q <= '0;
      done_len_q  <= '0;
    end else begin
      state_q     <= state_d;
      sram_q      <= sram_d;
      head_q      <= head_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      vld_q       <= vld_d;
      data_q      <= data_d;
      eop_q       <= eop_d;
      done_sram_q <= done_sram_d;
      done_len_q  <= done_len_d;
    end
  end

endmodule

// File: tb/tb_port_rd_backend.sv
// Scoreboard bench for port_rd_backend: instance 0 uses read latency 1, instance 1
// uses read latency 3; the SRAM model returns {sel, addr} as the word contents.
module tb_port_rd_backend;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 11;
  localparam int unsigned LW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  logic          rst[2];
  logic          avail[2];
  logic          ready[2];
  logic [4:0]    sram_i[2];
  logic [AW-1:0] head_i[2];
  logic [LW-1:0] len_i[2];
  logic          ack[2];
  logic          rd_en[2];
  logic [4:0]    rsel[2];
  logic [AW-1:0] raddr[2];
  logic [DW-1:0] mdata[2];
  logic          sop[2];
  logic          vld[2];
  logic [DW-1:0] rdo[2];
  logic          eop[2];
  logic          done[2];
  logic [4:0]    dsram[2];
  logic [LW-1:0] dlen[2];
  logic          busy[2];

  port_rd_backend #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .RD_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst[0]), .pkt_avail(avail[0]), .pkt_sram(sram_i[0]),
    .pkt_head(head_i[0]), .pkt_len(len_i[0]), .pkt_ack(ack[0]),
    .sram_rd_en(rd_en[0]), .sram_rd_sel(rsel[0]), .sram_rd_addr(raddr[0]),
    .sram_rd_data(mdata[0]), .ready(ready[0]), .rd_sop(sop[0]), .rd_vld(vld[0]),
    .rd_data(rdo[0]), .rd_eop(eop[0]), .done(done[0]), .done_sram(dsram[0]),
    .done_len(dlen[0]), .busy(busy[0])
  );

  port_rd_backend #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst[1]), .pkt_avail(avail[1]), .pkt_sram(sram_i[1]),
    .pkt_head(head_i[1]), .pkt_len(len_i[1]), .pkt_ack(ack[1]),
    .sram_rd_en(rd_en[1]), .sram_rd_sel(rsel[1]), .sram_rd_addr(raddr[1]),
    .sram_rd_data(mdata[1]), .ready(ready[1]), .rd_sop(sop[1]), .rd_vld(vld[1]),
    .rd_data(rdo[1]), .rd_eop(eop[1]), .done(done[1]), .done_sram(dsram[1]),
    .done_len(dlen[1]), .busy(busy[1])
  );

  // SRAM models: latency 1 and latency 3, contents = {sel, addr}
  logic [DW-1:0] m1;
  logic [DW-1:0] m3[3];
  always @(posedge clk) begin
    m1    <= {rsel[0], raddr[0]};
    m3[0] <= {rsel[1], raddr[1]};
    m3[1] <= m3[0];
    m3[2] <= m3[1];
  end
  assign mdata[0] = m1;
  assign mdata[1] = m3[2];

  typedef struct {
    int unsigned d;
    int unsigned cyc;
    logic [31:0] val;
    logic [31:0] aux;
    logic [31:0] aux2;
  } exp_t;

  exp_t q_sop[$];
  exp_t q_rd[$];
  exp_t q_wd[$];
  exp_t q_done[$];

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got 0x%0h expected 0x%0h", nm, d, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        if (!rst[d]) begin
          if (sop[d]) begin
            if (q_sop.size() == 0) chk("sop_unexpected", d, 32'(sop[d]), 0);
            else begin
              e = q_sop.pop_front();
              chk("sop_dut", d, 32'(d), e.d);
              chk("sop_cycle", d, cyc, e.cyc);
            end
            chk("sop_vld_overlap", d, 32'(vld[d]), 0);
          end
          if (rd_en[d]) begin
            if (q_rd.size() == 0) chk("rd_unexpected", d, 32'(rd_en[d]), 0);
            else begin
              e = q_rd.pop_front();
              chk("rd_cycle", d, cyc, e.cyc);
              chk("rd_sel_addr", d, 32'({rsel[d], raddr[d]}), e.val);
            end
          end
          if (vld[d]) begin
            if (q_wd.size() == 0) chk("vld_unexpected", d, 32'(vld[d]), 0);
            else begin
              e = q_wd.pop_front();
              chk("vld_cycle", d, cyc, e.cyc);
              chk("rd_data", d, 32'(rdo[d]), e.val);
            end
          end
          if (eop[d] || done[d]) begin
            if (q_done.size() == 0) chk("done_unexpected", d, 32'({eop[d], done[d]}), 0);
            else begin
              e = q_done.pop_front();
              chk("done_cycle", d, cyc, e.cyc);
              chk("eop_pulse", d, 32'(eop[d]), 1);
              chk("done_pulse", d, 32'(done[d]), 1);
              chk("done_sram", d, 32'(dsram[d]), e.val);
              chk("done_len", d, 32'(dlen[d]), e.aux);
              chk("rd_data_hold", d, 32'(rdo[d]), e.aux2);
            end
            chk("eop_vld_overlap", d, 32'(vld[d]), 0);
          end
        end
      end
    end
  end

  task automatic send(input int d, input logic [4:0] s, input logic [AW-1:0] h,
                      input logic [LW-1:0] l, input bit keep, output int unsigned t);
    bit ok = 1'b0;
    avail[d] = 1'b1; sram_i[d] = s; head_i[d] = h; len_i[d] = l;
    t = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (ack[d]) begin ok = 1'b1; t = cyc; end
    end
    if (!ok) chk("ack_timeout", d, 32'(ack[d]), 1);
    @(posedge clk); #1;
    if (!keep) avail[d] = 1'b0;
  endtask

  task automatic push_exp(input int d, input logic [4:0] s, input logic [AW-1:0] h,
                          input logic [LW-1:0] l, input int unsigned lat, input int unsigned t,
                          input int unsigned nrd, input int unsigned nwd, input bit wdone);
    exp_t e;
    logic [AW-1:0] a;
    e.d = 32'(d); e.val = 0; e.aux = 0; e.aux2 = 0;
    e.cyc = t + 1;
    q_sop.push_back(e);
    for (int unsigned i = 0; i < nrd; i++) begin
      a = h + AW'(i);
      e.cyc = t + 1 + i; e.val = 32'({s, a});
      q_rd.push_back(e);
    end
    for (int unsigned i = 0; i < nwd; i++) begin
      a = h + AW'(i);
      e.cyc = t + 1 + lat + i; e.val = 32'({s, a});
      q_wd.push_back(e);
    end
    if (wdone) begin
      a = h + AW'(l) - AW'(1);
      e.cyc = t + 32'(l) + 1 + lat; e.val = 32'(s); e.aux = 32'(l); e.aux2 = 32'({s, a});
      q_done.push_back(e);
    end
  endtask

  task automatic wait_quiet(input int d);
    bit ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (q_sop.size() + q_rd.size() + q_wd.size() + q_done.size() == 0 && !busy[d]) ok = 1'b1;
    end
    if (!ok) chk("drain_timeout", d, 32'(q_sop.size() + q_rd.size() + q_wd.size() + q_done.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk({tag, "_ack"}, d, 32'(ack[d]), 0);
    chk({tag, "_busy"}, d, 32'(busy[d]), 0);
    chk({tag, "_rd_en"}, d, 32'(rd_en[d]), 0);
    chk({tag, "_rd_sel"}, d, 32'(rsel[d]), 0);
    chk({tag, "_rd_addr"}, d, 32'(raddr[d]), 0);
    chk({tag, "_sop"}, d, 32'(sop[d]), 0);
    chk({tag, "_vld"}, d, 32'(vld[d]), 0);
    chk({tag, "_data"}, d, 32'(rdo[d]), 0);
    chk({tag, "_eop"}, d, 32'(eop[d]), 0);
    chk({tag, "_done"}, d, 32'(done[d]), 0);
    chk({tag, "_done_sram"}, d, 32'(dsram[d]), 0);
    chk({tag, "_done_len"}, d, 32'(dlen[d]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t, t2, tr;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; avail[d] = 1'b1; ready[d] = 1'b1;
      sram_i[d] = 5'd3; head_i[d] = 11'h123; len_i[d] = 9'd4;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero(0, "reset");
    chk_zero(1, "reset");
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin rst[d] = 1'b0; avail[d] = 1'b0; end
    mon_en = 1'b1;
    @(posedge clk); #1;

    // single packet, latency 1
    send(0, 5'd7, 11'h010, 9'd4, 1'b0, t);
    push_exp(0, 5'd7, 11'h010, 9'd4, 1, t, 4, 4, 1'b1);
    wait_quiet(0);

    // address wrap
    send(0, 5'd3, 11'h7FE, 9'd4, 1'b0, t);
    push_exp(0, 5'd3, 11'h7FE, 9'd4, 1, t, 4, 4, 1'b1);
    wait_quiet(0);

    // back-to-back with pkt_avail held
    send(0, 5'd1, 11'h100, 9'd2, 1'b1, t);
    push_exp(0, 5'd1, 11'h100, 9'd2, 1, t, 2, 2, 1'b1);
    send(0, 5'd2, 11'h200, 9'd3, 1'b0, t2);
    chk("b2b_ack_cycle", 0, t2, t + 4);
    push_exp(0, 5'd2, 11'h200, 9'd3, 1, t2, 3, 3, 1'b1);
    wait_quiet(0);

    // ready gating, then ready dropped mid-packet
    ready[0] = 1'b0; avail[0] = 1'b1; sram_i[0] = 5'd9; head_i[0] = 11'h050; len_i[0] = 9'd3;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("gated_ack", 0, 32'(ack[0]), 0);
      chk("gated_busy", 0, 32'(busy[0]), 0);
    end
    @(posedge clk); #1;
    ready[0] = 1'b1;
    tr = cyc;
    send(0, 5'd9, 11'h050, 9'd3, 1'b0, t);
    chk("ready_ack_cycle", 0, t, tr);
    ready[0] = 1'b0;
    push_exp(0, 5'd9, 11'h050, 9'd3, 1, t, 3, 3, 1'b1);
    wait_quiet(0);
    ready[0] = 1'b1;

    // zero-length descriptor: acked, no traffic
    send(0, 5'd4, 11'h020, 9'd0, 1'b0, t);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("zlen_busy", 0, 32'(busy[0]), 0);
      chk("zlen_ack", 0, 32'(ack[0]), 0);
    end
    @(posedge clk); #1;

    // reset mid-stream on the latency-3 instance after 3 of 8 words
    send(1, 5'd6, 11'h300, 9'd8, 1'b0, t);
    push_exp(1, 5'd6, 11'h300, 9'd8, 3, t, 6, 3, 1'b0);
    while (cyc < t + 7) begin @(posedge clk); #1; end
    rst[1] = 1'b1; avail[1] = 1'b1; sram_i[1] = 5'd5; head_i[1] = 11'h400; len_i[1] = 9'd2;
    @(negedge clk);
    chk("rst_ack", 1, 32'(ack[1]), 0);
    chk("rst_busy", 1, 32'(busy[1]), 0);
    @(posedge clk); #1;
    rst[1] = 1'b0; avail[1] = 1'b0;
    @(negedge clk);
    chk_zero(1, "midrst");
    repeat (8) @(negedge clk);
    chk("midrst_pending", 1, 32'(q_sop.size() + q_rd.size() + q_wd.size() + q_done.size()), 0);
    @(posedge clk); #1;
    send(1, 5'd5, 11'h400, 9'd2, 1'b0, t);
    push_exp(1, 5'd5, 11'h400, 9'd2, 3, t, 2, 2, 1'b1);
    wait_quiet(1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/port_rd_backend.md
Name: port_rd_backend

Overview:
- Per-egress-port read engine; one instance per output port, 16 in total.
- Accepts one packet descriptor at a time from the port's dequeue scheduler: SRAM index, head address and length in words.
- Streams the packet's words out of that SRAM by issuing sequential reads and drives the port's rd_sop/rd_vld/rd_data/rd_eop toward the device, gated by ready at packet boundaries.
- On completion it reports the freed space back to the SRAM side. It is the read-direction counterpart of the per-port write frontend.

Parameters:
- DATA_W, 16, word width of SRAM data and rd_data.
- ADDR_W, 11, SRAM word address width (2048 words per SRAM).
- LEN_W, 9, packet length field width in words, header word included.
- RD_LATENCY, 1, SRAM read latency in cycles; legal values are 1..3.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- pkt_avail  input  1  scheduler has a descriptor ready for this port.
- pkt_sram  input  5  SRAM holding the packet.
- pkt_head  input  ADDR_W  address of the packet's first (header) word.
- pkt_len  input  LEN_W  packet length in words.
- pkt_ack  output  1  descriptor consumed this cycle.
- sram_rd_en  output  1  read strobe.
- sram_rd_sel  output  5  SRAM index for the read.
- sram_rd_addr  output  ADDR_W  read address.
- sram_rd_data  input  DATA_W  read data, valid RD_LATENCY cycles after the matching sram_rd_en.
- ready  input  1  device can accept a new packet.
- rd_sop  output  1  start-of-packet pulse.
- rd_vld  output  1  rd_data valid.
- rd_data  output  DATA_W  packet word.
- rd_eop  output  1  end-of-packet pulse.
- done  output  1  one-cycle pulse when a packet has fully left.
- done_sram  output  5  SRAM index of the completed packet.
- done_len  output  LEN_W  number of words freed.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset, checked on the clock edge: every output register goes to 0, the FSM goes to IDLE, the in-flight valid pipeline is cleared. pkt_ack and busy are 0 while rst is high.
- FSM has three states: IDLE, ISSUE, DRAIN.
- IDLE:
  - pkt_ack = pkt_avail & ready & ~rst. pkt_ack is combinational and is high in IDLE only.
  - On pkt_ack: latch pkt_sram, pkt_head and pkt_len; issue counter := 0.
  - If pkt_len == 0: drop the descriptor. It is acked, but there is no rd_sop, no read and no done; stay in IDLE.
  - Otherwise go to ISSUE.
- ISSUE:
  - Each cycle: sram_rd_en = 1, sram_rd_sel = latched SRAM, sram_rd_addr = head + counter (mod 2^ADDR_W, natural wrap); counter increments.
  - rd_sop = 1 in the first ISSUE cycle only.
  - After the issue with counter == len-1, go to DRAIN.
- Valid pipeline: an RD_LATENCY-deep shift register tracks each issued read.
  - rd_vld = pipeline tail, aligned with sram_rd_data.
  - rd_data = sram_rd_data when rd_vld = 1; otherwise it holds its last value.
- DRAIN:
  - Wait until the last word has returned. rd_eop pulses the cycle after the last rd_vld.
  - done, done_sram = latched SRAM and done_len = len are asserted in that same cycle.
  - The FSM is in IDLE in the rd_eop cycle, so pkt_ack may fire then, and the next rd_sop follows in the next cycle.
- Timing with RD_LATENCY = 1, ack at cycle t, length L:
  - rd_sop at t+1.
  - rd_vld at t+2 .. t+L+1.
  - rd_eop and done at t+L+2.
  - General form: rd_eop at t+L+1+RD_LATENCY.
- ready is sampled only in IDLE. Deasserting ready mid-packet does not stall the stream.
- pkt_* inputs are ignored when not in IDLE.
- Reset mid-packet: the stream is aborted, words still returning are discarded, and no rd_eop or done is generated.
- Ordering guarantees: rd_sop never coincides with rd_vld; rd_eop never coincides with rd_vld.

Test Plan:
- Single packet: sram 7, head 0x010, len 4, ready=1, latency 1. Required: ack at t; rd_sop at t+1; reads at 0x010..0x013 on t+1..t+4; rd_vld at t+2..t+5 with SRAM contents in order; rd_eop and done at t+6 with done_sram=7, done_len=4.
- Address wrap: head 0x7FE, len 4. Required: reads at 0x7FE, 0x7FF, 0x000, 0x001.
- Back-to-back: two descriptors, len 2 then len 3, pkt_avail held high. Required: second ack in the same cycle as the first rd_eop; second rd_sop one cycle later; no overlap between the two packets.
- ready gating: ready=0 with pkt_avail=1 for 5 cycles. Required: no ack, busy=0. Then ready=1: ack in that cycle. Dropping ready to 0 mid-packet still yields the full L words and rd_eop.
- Zero length: pkt_len = 0. Required: pkt_ack=1 for one cycle; no sram_rd_en, rd_sop or done.
- Reset mid-stream: rst=1 after 3 of 8 words, with RD_LATENCY=3. Required: next cycle all outputs are 0; no rd_vld from reads already in flight; no done; a new descriptor is accepted normally after rst drops.
